// File: rtl/seg7_dec_display.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_dec_display
//  Purpose  : Accepts an N-bit signed/unsigned value over a valid/ready
//             handshake, converts it to DIGITS decimal digits with a
//             sequential double-dabble engine and drives registered
//             seven-segment outputs plus a sign segment.
//  Option   : SEG7_LZB_EN - when defined, leading zero digits are blanked.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_dec_display #(
    parameter int N          = 8,
    parameter int DIGITS     = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          value,
    input  logic                  is_signed,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   digit_seg,
    output logic [6:0]            sign_seg
);

    // Decimal digits needed for 2^N-1 is floor(N*log10(2))+1.
    localparam int DMAX = (N * 30103) / 100000 + 1;
    // BCD register is never narrower than the display, which keeps indexing simple.
    localparam int NB   = (DMAX > DIGITS) ? DMAX : DIGITS;
    localparam int CW   = $clog2(N + 1);

    localparam logic [6:0] SEG_BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        mag_q, mag_d;
    logic [4*NB-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;

    logic                done_q;
    logic                ovf_q;
    logic [7*DIGITS-1:0] seg_q;
    logic [6:0]          sign_q;

    logic [4*NB-1:0]     w_adj;
    logic                w_ovf;
    logic [7*DIGITS-1:0] w_seg;
    logic [6:0]          w_sign;
    logic [3:0]          w_nib;
    logic [6:0]          w_code;
`ifdef SEG7_LZB_EN
    logic                w_seen;
`endif

    // Lit-segment pattern (gfedcba) for a BCD digit.
    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 7'h3F;
            4'd1:    digit_code = 7'h06;
            4'd2:    digit_code = 7'h5B;
            4'd3:    digit_code = 7'h4F;
            4'd4:    digit_code = 7'h66;
            4'd5:    digit_code = 7'h6D;
            4'd6:    digit_code = 7'h7D;
            4'd7:    digit_code = 7'h07;
            4'd8:    digit_code = 7'h7F;
            4'd9:    digit_code = 7'h6F;
            default: digit_code = 7'h00;
        endcase
    endfunction

    // Map a lit-segment pattern onto the board's drive polarity.
    function automatic logic [6:0] polarity(input logic [6:0] c);
        polarity = (ACTIVE_LOW != 0) ? ~c : c;
    endfunction

    // Add-3 correction: every nibble of 5 or more is bumped before the shift.
    always_comb begin
        w_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // State register and conversion datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    // Next-state logic: accept in IDLE, N shift iterations, one DONE cycle.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    neg_d   = is_signed & value[N-1];
                    // N-bit negate: the most negative value maps to 2^(N-1) exactly.
                    mag_d   = (is_signed & value[N-1]) ? (~value + N'(1)) : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, mag_d} = {w_adj, mag_q} << 1;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Segment decode of the finished BCD value, with overflow and blanking.
    always_comb begin
        w_ovf  = 1'b0;
        w_seg  = '0;
        w_nib  = 4'd0;
        w_code = 7'h00;
`ifdef SEG7_LZB_EN
        w_seen = 1'b0;
`endif
        for (int i = DIGITS; i < NB; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0)
                w_ovf = 1'b1;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_nib = bcd_q[4*i +: 4];
`ifdef SEG7_LZB_EN
            if ((w_nib != 4'd0) || (i == 0))
                w_seen = 1'b1;
            w_code = w_seen ? digit_code(w_nib) : 7'h00;
`else
            w_code = digit_code(w_nib);
`endif
            if (w_ovf)
                w_code = 7'h40;
            w_seg[7*i +: 7] = polarity(w_code);
        end
        w_sign = polarity(neg_q ? 7'h40 : 7'h00);
    end

    // Output registers: updated only on the DONE edge, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q  <= {DIGITS{SEG_BLANK}};
            sign_q <= SEG_BLANK;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                seg_q  <= w_seg;
                sign_q <= w_sign;
                ovf_q  <= w_ovf;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign digit_seg = seg_q;
    assign sign_seg  = sign_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_dec_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_dec_display
//  Purpose  : Table-driven bench for seg7_dec_display; a 3-digit and a
//             2-digit instance (N=8, active-low) share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_dec_display;

    logic        clk;
    logic        reset;
    logic [7:0]  value;
    logic        is_signed;
    logic        in_valid;

    logic        in_ready3, busy3, done3, ovf3;
    logic [20:0] seg3;
    logic [6:0]  sign3;
    logic        in_ready2, busy2, done2, ovf2;
    logic [13:0] seg2;
    logic [6:0]  sign2;

    int n_vec  = 0;
    int n_fail = 0;

    seg7_dec_display #(.N(8), .DIGITS(3), .ACTIVE_LOW(1)) u_dut3 (
        .clk(clk), .reset(reset), .value(value), .is_signed(is_signed),
        .in_valid(in_valid), .in_ready(in_ready3), .busy(busy3), .done(done3),
        .overflow(ovf3), .digit_seg(seg3), .sign_seg(sign3)
    );

    seg7_dec_display #(.N(8), .DIGITS(2), .ACTIVE_LOW(1)) u_dut2 (
        .clk(clk), .reset(reset), .value(value), .is_signed(is_signed),
        .in_valid(in_valid), .in_ready(in_ready2), .busy(busy2), .done(done2),
        .overflow(ovf2), .digit_seg(seg2), .sign_seg(sign2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: input plus expected decimal digits (A = '-', B = blank).
    typedef struct packed {
        logic [7:0]  val;
        logic        sgn;
        logic [11:0] d3;
        logic        neg;
        logic        ovf3;
        logic [7:0]  d2;
        logic        ovf2;
    } vec_t;

    vec_t tbl [12];

    logic [20:0] prev3;
    logic [13:0] prev2;

    // Active-low segment patterns for hand-chosen digit symbols.
    function automatic logic [6:0] seg_al(input logic [3:0] d);
        case (d)
            4'h0: seg_al = 7'h40;  4'h1: seg_al = 7'h79;
            4'h2: seg_al = 7'h24;  4'h3: seg_al = 7'h30;
            4'h4: seg_al = 7'h19;  4'h5: seg_al = 7'h12;
            4'h6: seg_al = 7'h02;  4'h7: seg_al = 7'h78;
            4'h8: seg_al = 7'h00;  4'h9: seg_al = 7'h10;
            4'hA: seg_al = 7'h3F;
            default: seg_al = 7'h7F;
        endcase
    endfunction

    // Replace leading zeros by blanks when the blanking option is built in.
    function automatic logic [11:0] lzb(input logic [11:0] d, input int k);
        logic [11:0] r;
        r = d;
`ifdef SEG7_LZB_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int j = k - 1; j >= 1; j--) begin
                if (d[4*j +: 4] != 4'h0) seen = 1'b1;
                if (!seen) r[4*j +: 4] = 4'hB;
            end
        end
`endif
        return r;
    endfunction

    function automatic logic [20:0] expand(input logic [11:0] d, input int k);
        logic [20:0] r;
        logic [11:0] b;
        r = '0;
        b = lzb(d, k);
        for (int j = 0; j < k; j++) r[7*j +: 7] = seg_al(b[4*j +: 4]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [20:0] e3;
        logic [13:0] e2;
        logic [6:0]  es;
        logic [20:0] e2w;
        e3  = expand(v.d3, 3);
        e2w = expand({4'h0, v.d2}, 2);
        e2  = e2w[13:0];
        es  = v.neg ? 7'h3F : 7'h7F;
        @(negedge clk);
        value = v.val; is_signed = v.sgn; in_valid = 1'b1;
        chk("in_ready", {31'd0, in_ready3}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; value = ~v.val; is_signed = ~v.sgn;
        chk("busy", {31'd0, busy3}, 32'd1);
        lat = 0;
        while (!done3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4 && !done3) begin
                chk("held3", {11'd0, seg3}, {11'd0, prev3});
                chk("held2", {18'd0, seg2}, {18'd0, prev2});
            end
        end
        chk("latency", lat, 32'd9);
        chk("seg3",  {11'd0, seg3},  {11'd0, e3});
        chk("sign3", {25'd0, sign3}, {25'd0, es});
        chk("ovf3",  {31'd0, ovf3},  {31'd0, v.ovf3});
        chk("done2", {31'd0, done2}, 32'd1);
        chk("seg2",  {18'd0, seg2},  {18'd0, e2});
        chk("sign2", {25'd0, sign2}, {25'd0, es});
        chk("ovf2",  {31'd0, ovf2},  {31'd0, v.ovf2});
        chk("ready_in_done", {31'd0, in_ready3}, 32'd1);
        prev3 = e3;
        prev2 = e2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [20:0] t;
        //            val    sgn   d3       neg   ov3   d2     ov2
        tbl[0]  = '{8'd255, 1'b0, 12'h255, 1'b0, 1'b0, 8'hAA, 1'b1};
        tbl[1]  = '{8'h80,  1'b1, 12'h128, 1'b1, 1'b0, 8'hAA, 1'b1};
        tbl[2]  = '{8'hFF,  1'b1, 12'h001, 1'b1, 1'b0, 8'h01, 1'b0};
        tbl[3]  = '{8'd100, 1'b0, 12'h100, 1'b0, 1'b0, 8'hAA, 1'b1};
        tbl[4]  = '{8'd99,  1'b0, 12'h099, 1'b0, 1'b0, 8'h99, 1'b0};
        tbl[5]  = '{8'd0,   1'b1, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{8'h80,  1'b0, 12'h128, 1'b0, 1'b0, 8'hAA, 1'b1};
        tbl[7]  = '{8'd7,   1'b0, 12'h007, 1'b0, 1'b0, 8'h07, 1'b0};
        tbl[8]  = '{8'h9C,  1'b1, 12'h100, 1'b1, 1'b0, 8'hAA, 1'b1};
        tbl[9]  = '{8'h7F,  1'b1, 12'h127, 1'b0, 1'b0, 8'hAA, 1'b1};
        tbl[10] = '{8'd10,  1'b0, 12'h010, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[11] = '{8'hF6,  1'b0, 12'h246, 1'b0, 1'b0, 8'hAA, 1'b1};

        reset = 1'b1; in_valid = 1'b0; value = 8'd0; is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg3",  {11'd0, seg3},  {11'd0, 21'h1FFFFF});
        chk("rst_sign3", {25'd0, sign3}, {25'd0, 7'h7F});
        chk("rst_ready", {31'd0, in_ready3}, 32'd1);
        chk("rst_busy",  {31'd0, busy3}, 32'd0);
        chk("rst_done",  {31'd0, done3}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf3},  32'd0);
        chk("rst_seg2",  {18'd0, seg2},  {18'd0, 14'h3FFF});
        @(negedge clk);
        reset = 1'b0;
        prev3 = 21'h1FFFFF;
        prev2 = 14'h3FFF;

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // in_valid during SHIFT must be ignored and must not queue a conversion.
        @(negedge clk);
        value = 8'd7; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        value = 8'd42; in_valid = 1'b1;
        chk("ready_busy", {31'd0, in_ready3}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; value = 8'd0;
        cnt = 0;
        while (!done3 && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("ign_done", {31'd0, done3}, 32'd1);
        t = expand(12'h007, 3);
        chk("ign_seg3", {11'd0, seg3}, {11'd0, t});
        chk("ign_ovf3", {31'd0, ovf3}, 32'd0);
        @(posedge clk); #1;
        chk("pulse_len", {31'd0, done3}, 32'd0);
        chk("no_requeue", {31'd0, busy3}, 32'd0);

        // Reset mid-conversion aborts: no done pulse, blank display.
        @(negedge clk);
        value = 8'd42; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abt_seg3",  {11'd0, seg3},  {11'd0, 21'h1FFFFF});
        chk("abt_sign3", {25'd0, sign3}, {25'd0, 7'h7F});
        chk("abt_seg2",  {18'd0, seg2},  {18'd0, 14'h3FFF});
        chk("abt_done",  {31'd0, done3}, 32'd0);
        chk("abt_busy",  {31'd0, busy3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("abt_ready", {31'd0, in_ready3}, 32'd1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done3 || done2) cnt++;
        end
        chk("abt_nodone", cnt, 32'd0);
        chk("abt_blank_held", {11'd0, seg3}, {11'd0, 21'h1FFFFF});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
